decode_stage: RTL and testbench
===============================

# decode_stage

Instruction-decode stage of the five-stage RV32I pipeline. It sits between fetch and execute, holds the IF/ID pipeline register, and drives the register file read addresses. It bypasses the same-cycle writeback to avoid the register file's read-before-write hazard, generates immediates and control, and holds the ID/EX pipeline register with stall/flush support.

## Interface
- `XLEN`, 32, datapath width
- `REG_AW`, 5, register address width
- `clk  in  1  rising-edge clock`
- `rst  in  1  reset`; synchronous, active-high; one clock, all state in `clk` domain
- `if_valid  in  1  fetch presents an instruction`
- `if_instr  in  32  instruction word`
- `if_pc, if_pc4  in  32  PC and PC+4 of instruction`
- `stall  in  1  hazard unit: hold IF/ID, bubble into ID/EX`
- `flush  in  1  taken branch/jump in EX: kill IF/ID and ID/EX`
- `rf_a1, rf_a2  out  5  register file read addresses (rs1, rs2)`
- `rf_rd1, rf_rd2  in  32  register file read data (combinational)`
- `wb_we, wb_rd[4:0], wb_data[31:0]  in  -  writeback port, same signals that drive the register file write side`
- `ex_valid  out  1  ID/EX holds a real instruction`
- `ex_pc, ex_pc4, ex_rs1_val, ex_rs2_val, ex_imm  out  32  ID/EX data`
- `ex_rs1, ex_rs2, ex_rd  out  5  register indices, used for EX/MEM forwarding`
- `ex_opcode[6:0], ex_funct3[2:0], ex_funct7b5  out  -  raw fields for ALU decode`
- `ex_reg_write, ex_illegal  out  1  control`

## Operation
- IF/ID register:
  - Loads `if_valid`/`if_instr`/`if_pc`/`if_pc4` on each edge unless `stall`.
  - When `flush` is asserted, IF/ID valid is cleared.
  - `flush` has priority over `stall`.
- Register reads:
  - `rf_a1` = IF/ID instr[19:15] and `rf_a2` = instr[24:20], always driven, including for non-R types.
- Operand select, per source independently, in priority order:
  - rs == 0 gives 0. The register file does not hard-wire x0, so this stage does.
  - `wb_we` && `wb_rd` == rs gives `wb_data`.
  - Otherwise `rf_rd1`/`rf_rd2`.
- Immediate, sign-extended from instr[31], by opcode:
  - I-type: 0000011, 0010011, 1100111
  - S-type: 0100011
  - B-type: 1100011, bit0 = 0
  - U-type: 0110111, 0010111, imm[11:0] = 0
  - J-type: 1101111, bit0 = 0
  - R-type: 0110011, imm = 0
- `reg_write` is 1 for R, I, U, J, and JALR types, and only when rd != 0.
- Any other opcode sets `illegal` = 1 and forces `reg_write` = 0.
- ID/EX register, on each edge:
  - `flush` or `stall` or IF/ID invalid loads a bubble: `ex_valid` = 0, `ex_reg_write` = 0, `ex_illegal` = 0, all other fields 0.
  - Otherwise it loads the decoded fields with `ex_valid` = 1.
- No combinational path from `ex_*` outputs to `stall`/`flush`.

## Timing
- Reset, synchronous: IF/ID valid = 0, instr = 0x00000013 (NOP). All `ex_*` = 0, including `ex_valid`, `ex_reg_write`, `ex_illegal`. `rst` overrides `stall`/`flush`.
- Latency: instruction accepted at edge N (IF/ID) is decoded in cycle N+1. It appears on `ex_*` after edge N+1, which is 2 edges total.
- Stall of k cycles:
  - IF/ID is unchanged for k edges, and `ex_valid` = 0 for k cycles.
  - The held instruction is re-read from the register file every cycle, so writebacks during the stall are picked up.
  - The instruction then issues exactly once.
- Flush:
  - Both stages are bubbles after the edge.
  - The instruction presented on `if_*` in the flush cycle is discarded.
- Bypass is combinational within the decode cycle. A writeback one cycle earlier is already in the register file and needs no bypass.
- Reset asserted mid-stream: the next edge empties both stages, with no partial issue.

## Structure
- `riscv_pkg` holds:
  - opcode localparams (`OP_LOAD`, `OP_IMM`, `OP_JALR`, `OP_STORE`, `OP_BRANCH`, `OP_LUI`, `OP_AUIPC`, `OP_JAL`, `OP_REG`)
  - `imm_t` enum (`IMM_I`, `IMM_S`, `IMM_B`, `IMM_U`, `IMM_J`, `IMM_NONE`)
  - `NOP_INSTR` = 32'h0000_0013
  - packed struct `id_ex_t` for the ID/EX register
- Sub-module `imm_gen`: combinational, takes instr[31:0] and returns imm[31:0] plus the `imm_t` type. It is reused by the branch predictor later.

## Test plan
- After reset, apply `addi x5,x0,7` (0x00700293) → 2 edges later: `ex_valid`=1, `ex_rd`=5, `ex_imm`=7, `ex_rs1_val`=0, `ex_reg_write`=1.
- `add x1,x3,x4` (0x004180B3) decoded while `wb_we`=1, `wb_rd`=3, `wb_data`=0xDEADBEEF, with the register file returning 3 → `ex_rs1_val`=0xDEADBEEF, `ex_rs2_val`=4.
- x0 read with `rf_rd1`=0x55 and a writeback of 5 to x0 in the same cycle → `ex_rs1_val`=0. `addi x0,x0,1` → `ex_reg_write`=0.
- Immediates:
  - `beq x0,x0,-4` (0xFE000EE3) → `ex_imm`=0xFFFFFFFC, `ex_reg_write`=0.
  - `sw x2,8(x1)` (0x0020A423) → `ex_imm`=8.
  - opcode 0x7F → `ex_illegal`=1.
- `stall` for 2 cycles with an instruction in IF/ID → `ex_valid`=0,0, then the instruction appears once. Asserting `stall`+`flush` together → both stages are bubbles and the instruction is lost.
- `rst` asserted with both stages full → next cycle `ex_valid`=0 and all `ex_*`=0. After release, the first instruction again takes 2 edges to reach `ex_*`.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats and the ID/EX register layout.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc4;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic              funct7b5;
        logic              reg_write;
        logic              illegal;
    } id_ex_t;

    // x0 is not hard-wired in the register file, and a same-cycle writeback
    // is not yet visible there, so both cases are resolved here.
    function automatic logic [XLEN-1:0] sel_operand(
        input logic [REG_AW-1:0] rs,
        input logic [XLEN-1:0]   rf_val,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_rd,
        input logic [XLEN-1:0]   wb_data
    );
        if (rs == '0)
            return '0;
        else if (wb_we && (wb_rd == rs))
            return wb_data;
        else
            return rf_val;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extractor; also classifies the instruction's immediate format.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] imm,
    output imm_t            imm_type
);

    always_comb begin
        imm_type = IMM_NONE;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR: imm_type = IMM_I;
            OP_STORE:                 imm_type = IMM_S;
            OP_BRANCH:                imm_type = IMM_B;
            OP_LUI, OP_AUIPC:         imm_type = IMM_U;
            OP_JAL:                   imm_type = IMM_J;
            default:                  imm_type = IMM_NONE;
        endcase
    end

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, operand read with writeback bypass, immediate/control
// decode and the ID/EX register with stall (bubble) and flush (kill) handling.
module decode_stage
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [XLEN-1:0]   if_instr,
    input  logic [XLEN-1:0]   if_pc,
    input  logic [XLEN-1:0]   if_pc4,
    input  logic              stall,
    input  logic              flush,
    output logic [REG_AW-1:0] rf_a1,
    output logic [REG_AW-1:0] rf_a2,
    input  logic [XLEN-1:0]   rf_rd1,
    input  logic [XLEN-1:0]   rf_rd2,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_pc4,
    output logic [XLEN-1:0]   ex_rs1_val,
    output logic [XLEN-1:0]   ex_rs2_val,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [6:0]        ex_opcode,
    output logic [2:0]        ex_funct3,
    output logic              ex_funct7b5,
    output logic              ex_reg_write,
    output logic              ex_illegal
);

    logic            ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
    logic [XLEN-1:0] ifid_pc_q,    ifid_pc_d;
    logic [XLEN-1:0] ifid_pc4_q,   ifid_pc4_d;
    id_ex_t          id_ex_q,      id_ex_d;

    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [6:0]        opcode;
    logic [XLEN-1:0]   imm;
    imm_t              imm_type;
    logic              illegal;
    logic              reg_write;

    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        if (flush) begin
            ifid_valid_d = 1'b0;
        end else if (!stall) begin
            ifid_valid_d = if_valid;
            ifid_instr_d = if_instr;
            ifid_pc_d    = if_pc;
            ifid_pc4_d   = if_pc4;
        end
    end

    assign rs1    = ifid_instr_q[19:15];
    assign rs2    = ifid_instr_q[24:20];
    assign rd     = ifid_instr_q[11:7];
    assign opcode = ifid_instr_q[6:0];
    assign rf_a1  = rs1;
    assign rf_a2  = rs2;

    imm_gen u_imm_gen (
        .instr    (ifid_instr_q),
        .imm      (imm),
        .imm_type (imm_type)
    );

    // R-type is the only legal opcode without an immediate format.
    assign illegal   = (imm_type == IMM_NONE) && (opcode != OP_REG);
    assign reg_write = !illegal && (imm_type != IMM_S) && (imm_type != IMM_B) && (rd != '0);

    always_comb begin
        id_ex_d = '0;
        if (ifid_valid_q && !stall && !flush) begin
            id_ex_d.valid     = 1'b1;
            id_ex_d.pc        = ifid_pc_q;
            id_ex_d.pc4       = ifid_pc4_q;
            id_ex_d.rs1_val   = sel_operand(rs1, rf_rd1, wb_we, wb_rd, wb_data);
            id_ex_d.rs2_val   = sel_operand(rs2, rf_rd2, wb_we, wb_rd, wb_data);
            id_ex_d.imm       = imm;
            id_ex_d.rs1       = rs1;
            id_ex_d.rs2       = rs2;
            id_ex_d.rd        = rd;
            id_ex_d.opcode    = opcode;
            id_ex_d.funct3    = ifid_instr_q[14:12];
            id_ex_d.funct7b5  = ifid_instr_q[30];
            id_ex_d.reg_write = reg_write;
            id_ex_d.illegal   = illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            id_ex_q      <= '0;
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            id_ex_q      <= id_ex_d;
        end
    end

    assign ex_valid     = id_ex_q.valid;
    assign ex_pc        = id_ex_q.pc;
    assign ex_pc4       = id_ex_q.pc4;
    assign ex_rs1_val   = id_ex_q.rs1_val;
    assign ex_rs2_val   = id_ex_q.rs2_val;
    assign ex_imm       = id_ex_q.imm;
    assign ex_rs1       = id_ex_q.rs1;
    assign ex_rs2       = id_ex_q.rs2;
    assign ex_rd        = id_ex_q.rd;
    assign ex_opcode    = id_ex_q.opcode;
    assign ex_funct3    = id_ex_q.funct3;
    assign ex_funct7b5  = id_ex_q.funct7b5;
    assign ex_reg_write = id_ex_q.reg_write;
    assign ex_illegal   = id_ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected issues are queued as each instruction is decoded
// and compared when it appears on the ex_* outputs.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr, if_pc, if_pc4;
    logic        stall, flush;
    logic [4:0]  rf_a1, rf_a2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_pc4, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5, ex_reg_write, ex_illegal;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    localparam logic [31:0] I_ADDI5  = 32'h0070_0293; // addi x5,x0,7
    localparam logic [31:0] I_ADD    = 32'h0041_80B3; // add x1,x3,x4
    localparam logic [31:0] I_ADDI0  = 32'h0010_0013; // addi x0,x0,1
    localparam logic [31:0] I_BEQ    = 32'hFE00_0EE3; // beq x0,x0,-4
    localparam logic [31:0] I_SW     = 32'h0020_A423; // sw x2,8(x1)
    localparam logic [31:0] I_LUI    = 32'h1234_53B7; // lui x7,0x12345
    localparam logic [31:0] I_JAL    = 32'hFF9F_F0EF; // jal x1,-8
    localparam logic [31:0] I_ILL    = 32'h0000_007F;
    localparam logic [31:0] I_ADDI6  = 32'h0031_0313; // addi x6,x2,3

    decode_stage dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_pc4       (if_pc4),
        .stall        (stall),
        .flush        (flush),
        .rf_a1        (rf_a1),
        .rf_a2        (rf_a2),
        .rf_rd1       (rf_rd1),
        .rf_rd2       (rf_rd2),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_pc4       (ex_pc4),
        .ex_rs1_val   (ex_rs1_val),
        .ex_rs2_val   (ex_rs2_val),
        .ex_imm       (ex_imm),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_opcode    (ex_opcode),
        .ex_funct3    (ex_funct3),
        .ex_funct7b5  (ex_funct7b5),
        .ex_reg_write (ex_reg_write),
        .ex_illegal   (ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_fetch(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        if_valid = v;
        if_instr = instr;
        if_pc    = pc;
        if_pc4   = pc + 32'd4;
    endtask

    task automatic set_rf(input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic we, input logic [4:0] wrd, input logic [31:0] wdata);
        rf_rd1  = rd1;
        rf_rd2  = rd2;
        wb_we   = we;
        wb_rd   = wrd;
        wb_data = wdata;
    endtask

    task automatic expect_issue(input logic [31:0] instr, input logic [31:0] pc, input logic [4:0] rd,
                                input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                                input logic rw, input logic ill);
        exp_t e;
        e.instr = instr; e.pc = pc; e.rd = rd; e.rs1_val = v1; e.rs2_val = v2;
        e.imm = imm; e.rw = rw; e.ill = ill;
        sb.push_back(e);
    endtask

    // Advance one edge, then compare ex_* against the scoreboard (or against an all-zero bubble).
    task automatic tick(input logic exp_valid);
        exp_t e;
        logic [6:0] exp_op;
        @(posedge clk);
        #1;
        check("ex_valid", {31'b0, ex_valid}, {31'b0, exp_valid});
        if (ex_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_issue", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                exp_op = e.instr[6:0];
                $display("issue pc=%h instr=%h rd=%0d rs1_val=%h rs2_val=%h imm=%h rw=%0b ill=%0b",
                         ex_pc, e.instr, ex_rd, ex_rs1_val, ex_rs2_val, ex_imm, ex_reg_write, ex_illegal);
                check("ex_pc",        ex_pc,        e.pc);
                check("ex_pc4",       ex_pc4,       e.pc + 32'd4);
                check("ex_rd",        {27'b0, ex_rd}, {27'b0, e.rd});
                check("ex_opcode",    {25'b0, ex_opcode}, {25'b0, exp_op});
                check("ex_rs1_val",   ex_rs1_val,   e.rs1_val);
                check("ex_rs2_val",   ex_rs2_val,   e.rs2_val);
                check("ex_imm",       ex_imm,       e.imm);
                check("ex_reg_write", {31'b0, ex_reg_write}, {31'b0, e.rw});
                check("ex_illegal",   {31'b0, ex_illegal},   {31'b0, e.ill});
            end
        end else begin
            check("bubble_zero",
                  {31'b0, |{ex_pc, ex_pc4, ex_rs1_val, ex_rs2_val, ex_imm, ex_rs1, ex_rs2, ex_rd,
                            ex_opcode, ex_funct3, ex_funct7b5, ex_reg_write, ex_illegal}},
                  32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive_fetch(1'b1, I_ADD, 32'h0000_0050);
        set_rf(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick(1'b0);
        tick(1'b0);

        // addi x5,x0,7: rs1=x0 must read 0 despite rf_rd1
        rst = 1'b0;
        drive_fetch(1'b1, I_ADDI5, 32'h100);
        tick(1'b0);
        check("rf_a1_addi", {27'b0, rf_a1}, 32'd0);
        check("rf_a2_addi", {27'b0, rf_a2}, 32'd7);
        set_rf(32'h99, 32'h22, 1'b0, 5'd0, 32'h0);
        expect_issue(I_ADDI5, 32'h100, 5'd5, 32'h0, 32'h22, 32'd7, 1'b1, 1'b0);
        drive_fetch(1'b1, I_ADD, 32'h104);
        tick(1'b1);

        // add x1,x3,x4 with same-cycle writeback to x3
        check("rf_a1_add", {27'b0, rf_a1}, 32'd3);
        check("rf_a2_add", {27'b0, rf_a2}, 32'd4);
        set_rf(32'd3, 32'd4, 1'b1, 5'd3, 32'hDEAD_BEEF);
        expect_issue(I_ADD, 32'h104, 5'd1, 32'hDEAD_BEEF, 32'd4, 32'd0, 1'b1, 1'b0);
        drive_fetch(1'b1, I_ADDI0, 32'h108);
        tick(1'b1);

        // addi x0,x0,1 with a writeback to x0: operand stays 0, no reg_write
        set_rf(32'h55, 32'h66, 1'b1, 5'd0, 32'd5);
        expect_issue(I_ADDI0, 32'h108, 5'd0, 32'h0, 32'h66, 32'd1, 1'b0, 1'b0);
        drive_fetch(1'b1, I_BEQ, 32'h10C);
        tick(1'b1);

        set_rf(32'h77, 32'h88, 1'b0, 5'd0, 32'h0);
        expect_issue(I_BEQ, 32'h10C, 5'd29, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0);
        drive_fetch(1'b1, I_SW, 32'h110);
        tick(1'b1);

        // writeback to an unrelated register must not bypass
        set_rf(32'h1000, 32'h2222, 1'b1, 5'd5, 32'h0BAD);
        expect_issue(I_SW, 32'h110, 5'd8, 32'h1000, 32'h2222, 32'd8, 1'b0, 1'b0);
        drive_fetch(1'b1, I_LUI, 32'h114);
        tick(1'b1);

        set_rf(32'hA, 32'hB, 1'b0, 5'd0, 32'h0);
        expect_issue(I_LUI, 32'h114, 5'd7, 32'hA, 32'hB, 32'h1234_5000, 1'b1, 1'b0);
        drive_fetch(1'b1, I_JAL, 32'h118);
        tick(1'b1);

        // jal: rs2 field (25) bypassed from writeback
        set_rf(32'd1, 32'd2, 1'b1, 5'd25, 32'h5A5A);
        expect_issue(I_JAL, 32'h118, 5'd1, 32'd1, 32'h5A5A, 32'hFFFF_FFF8, 1'b1, 1'b0);
        drive_fetch(1'b1, I_ILL, 32'h11C);
        tick(1'b1);

        set_rf(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_issue(I_ILL, 32'h11C, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        drive_fetch(1'b1, I_ADDI6, 32'h120);
        tick(1'b1);

        // two-cycle stall on addi x6,x2,3; writeback to x2 during the stall
        stall = 1'b1;
        drive_fetch(1'b1, I_ADD, 32'h124);
        set_rf(32'h10, 32'h3, 1'b0, 5'd0, 32'h0);
        tick(1'b0);
        set_rf(32'h10, 32'h3, 1'b1, 5'd2, 32'h2000);
        tick(1'b0);
        stall = 1'b0;
        set_rf(32'h2000, 32'h3, 1'b0, 5'd0, 32'h0);
        expect_issue(I_ADDI6, 32'h120, 5'd6, 32'h2000, 32'h3, 32'd3, 1'b1, 1'b0);
        tick(1'b1);

        // stall+flush together: add in IF/ID and sw on if_* are both lost
        stall = 1'b1;
        flush = 1'b1;
        drive_fetch(1'b1, I_SW, 32'h128);
        tick(1'b0);
        stall = 1'b0;
        flush = 1'b0;
        drive_fetch(1'b0, I_LUI, 32'h12C);
        tick(1'b0);
        tick(1'b0);

        // reset with both stages full
        drive_fetch(1'b1, I_ADDI5, 32'h200);
        tick(1'b0);
        set_rf(32'h0, 32'h22, 1'b0, 5'd0, 32'h0);
        expect_issue(I_ADDI5, 32'h200, 5'd5, 32'h0, 32'h22, 32'd7, 1'b1, 1'b0);
        drive_fetch(1'b1, I_LUI, 32'h204);
        tick(1'b1);
        rst = 1'b1;
        tick(1'b0);
        rst = 1'b0;
        drive_fetch(1'b1, I_JAL, 32'h300);
        tick(1'b0);
        set_rf(32'd1, 32'd2, 1'b0, 5'd0, 32'h0);
        expect_issue(I_JAL, 32'h300, 5'd1, 32'd1, 32'd2, 32'hFFFF_FFF8, 1'b1, 1'b0);
        drive_fetch(1'b0, I_ADD, 32'h304);
        tick(1'b1);
        tick(1'b0);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
